// File: rtl/sram_ctrl_pkg.sv
// Shared types and helpers for the asynchronous SRAM bridge.
package sram_ctrl_pkg;

   typedef enum logic [1:0] {ACC_BYTE, ACC_HALF, ACC_WORD, ACC_RSVD} acc_e;

   typedef enum logic [2:0] {S_IDLE, S_SETUP, S_STROBE, S_HOLD, S_DONE} state_e;

   localparam int SRAM_DEPTH = 1 << 19;

   // Index of the final byte cycle; the reserved size runs as a word.
   function automatic logic [1:0] last_idx(acc_e acc);
      case (acc)
         ACC_BYTE: return 2'd0;
         ACC_HALF: return 2'd1;
         default:  return 2'd3;
      endcase
   endfunction

   function automatic logic misaligned(acc_e acc, logic [1:0] lsb);
      case (acc)
         ACC_BYTE: return 1'b0;
         ACC_HALF: return lsb[0];
         ACC_WORD: return lsb != 2'd0;
         default:  return 1'b1;
      endcase
   endfunction

endpackage

// File: rtl/sram_ctrl.sv
// 32-bit bus to 8-bit async SRAM bridge; each access is split into little-endian byte cycles.
// Optional SRAM_CTRL_ALIGN_CHK_EN rejects misaligned/reserved requests with bus_err.
module sram_ctrl
   import sram_ctrl_pkg::*;
#(
   parameter int ADDR_W        = 19,
   parameter int STROBE_CYCLES = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              bus_req,
   output logic              bus_ready,
   input  logic              bus_w_rb,
   input  logic [1:0]        bus_acc,
   input  logic [ADDR_W-1:0] bus_addr,
   input  logic [31:0]       bus_wdata,
   output logic [31:0]       bus_rdata,
   output logic              bus_resp,
   output logic              bus_err,
   output logic              sram_ce_bar,
   output logic              sram_oe_bar,
   output logic              sram_we_bar,
   output logic [ADDR_W-1:0] sram_addr,
   output logic [7:0]        sram_dout,
   output logic              sram_doe,
   input  logic [7:0]        sram_din
);

   state_e            state, state_nx;
   logic [1:0]        idx, idx_nx;
   logic [3:0]        scnt;
   logic [ADDR_W-1:0] base;
   logic [31:0]       wdat;
   acc_e              acc;
   logic              wr;
   logic [31:0]       rbuf;
   logic              strobe_last;

   logic              ce_nx, oe_nx, we_nx, doe_nx, resp_nx, err_nx;
   logic [ADDR_W-1:0] addr_nx;
   logic [7:0]        dout_nx;

   assign strobe_last = (scnt == 4'(STROBE_CYCLES - 1));

   // Pin values are computed for the state being entered, so every output is a flop.
   always_comb begin
      state_nx = state;
      idx_nx   = idx;
      ce_nx    = 1'b1;
      oe_nx    = 1'b1;
      we_nx    = 1'b1;
      doe_nx   = 1'b0;
      resp_nx  = 1'b0;
      err_nx   = 1'b0;
      addr_nx  = sram_addr;
      dout_nx  = sram_dout;
      case (state)
         S_IDLE: begin
            if (bus_req) begin
`ifdef SRAM_CTRL_ALIGN_CHK_EN
               if (misaligned(acc_e'(bus_acc), bus_addr[1:0])) begin
                  state_nx = S_DONE;
                  resp_nx  = 1'b1;
                  err_nx   = 1'b1;
               end else
`endif
               begin
                  state_nx = S_SETUP;
                  idx_nx   = 2'd0;
                  ce_nx    = 1'b0;
                  addr_nx  = bus_addr;
                  doe_nx   = bus_w_rb;
                  dout_nx  = bus_w_rb ? bus_wdata[7:0] : sram_dout;
               end
            end
         end
         S_SETUP: begin
            state_nx = S_STROBE;
            ce_nx    = 1'b0;
            doe_nx   = wr;
            oe_nx    = wr;
            we_nx    = !wr;
         end
         S_STROBE: begin
            ce_nx  = 1'b0;
            doe_nx = wr;
            if (strobe_last) begin
               state_nx = S_HOLD;
            end else begin
               oe_nx = wr;
               we_nx = !wr;
            end
         end
         S_HOLD: begin
            if (idx != last_idx(acc)) begin
               state_nx = S_SETUP;
               idx_nx   = idx + 2'd1;
               ce_nx    = 1'b0;
               doe_nx   = wr;
               addr_nx  = base + {{(ADDR_W-2){1'b0}}, idx_nx};
               dout_nx  = wr ? wdat[{idx_nx, 3'b000} +: 8] : sram_dout;
            end else begin
               state_nx = S_DONE;
               resp_nx  = 1'b1;
            end
         end
         S_DONE: state_nx = S_IDLE;
         default: state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= S_IDLE;
         idx         <= 2'd0;
         scnt        <= 4'd0;
         base        <= '0;
         wdat        <= 32'd0;
         acc         <= ACC_BYTE;
         wr          <= 1'b0;
         rbuf        <= 32'd0;
         sram_ce_bar <= 1'b1;
         sram_oe_bar <= 1'b1;
         sram_we_bar <= 1'b1;
         sram_addr   <= '0;
         sram_dout   <= 8'd0;
         sram_doe    <= 1'b0;
         bus_resp    <= 1'b0;
         bus_err     <= 1'b0;
         bus_ready   <= 1'b1;
         bus_rdata   <= 32'd0;
      end else begin
         state       <= state_nx;
         idx         <= idx_nx;
         scnt        <= (state == S_STROBE) ? scnt + 4'd1 : 4'd0;
         sram_ce_bar <= ce_nx;
         sram_oe_bar <= oe_nx;
         sram_we_bar <= we_nx;
         sram_addr   <= addr_nx;
         sram_dout   <= dout_nx;
         sram_doe    <= doe_nx;
         bus_resp    <= resp_nx;
         bus_err     <= err_nx;
         bus_ready   <= (state_nx == S_IDLE);
         if (state == S_IDLE && bus_req) begin
            base <= bus_addr;
            wdat <= bus_wdata;
            acc  <= acc_e'(bus_acc);
            wr   <= bus_w_rb;
            rbuf <= 32'd0;
         end
         if (state == S_STROBE && strobe_last && !wr)
            rbuf[{idx, 3'b000} +: 8] <= sram_din;
         // Publish a read only once complete so bus_rdata holds the previous result meanwhile.
         if (state == S_HOLD && state_nx == S_DONE && !wr)
            bus_rdata <= rbuf;
      end
   end

endmodule

// File: doc/sram_ctrl.md
Name: sram_ctrl

Overview:
Bridges the internal 32-bit request bus to the external 512 KiB asynchronous SRAM (8-bit data, 19-bit address, active-low CE/OE/WE).
- Splits each byte, half-word or word access into sequenced byte cycles, little-endian, with programmable strobe width.
- Sits in the top level beside the NOR and timer peripherals. The bidirectional pad is resolved in the wrapper from sram_dout/sram_doe/sram_din.

Parameters:
ADDR_W, 19, SRAM byte address width (512 KiB)
STROBE_CYCLES, 1, cycles OE/WE held low per byte; legal 1..15

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-high
bus_req  in  1  request; held by requester until bus_ready seen high on same edge
bus_ready  out  1  high in IDLE only; request accepted on edge where bus_req&&bus_ready
bus_w_rb  in  1  1=write, 0=read
bus_acc  in  2  0=byte, 1=half, 2=word, 3=reserved
bus_addr  in  ADDR_W  byte address
bus_wdata  in  32  write data, byte0 in [7:0]
bus_rdata  out  32  read data, zero-extended
bus_resp  out  1  one-cycle completion pulse
bus_err  out  1  valid with bus_resp
sram_ce_bar  out  1  chip enable
sram_oe_bar  out  1  output enable
sram_we_bar  out  1  write enable
sram_addr  out  ADDR_W  SRAM address
sram_dout  out  8  write data to pad
sram_doe  out  1  pad output enable
sram_din  in  8  read data from pad

Behaviour:
- Clock and reset: one clock, clk. rst is asynchronous and active-high.
- Reset values (asynchronous): all *_bar=1, sram_addr=0, sram_dout=0, sram_doe=0, bus_resp=0, bus_err=0, bus_rdata=0, bus_ready=1. State=IDLE.
- Registered outputs: all outputs are registered; no combinational path from bus inputs to SRAM pins.
- Byte count N: 1/2/4 for acc 0/1/2. acc=3 is treated as word.
- On accept, latch addr, wdata, acc, w_rb; clear byte index i=0.
- FSM: IDLE -> SETUP -> STROBE -> HOLD, then either SETUP for the next byte or DONE, then IDLE.
  - SETUP (1 cycle): ce_bar=0, sram_addr=base+i (mod 2^ADDR_W, wraps 0x7FFFF->0x00000). For a write, sram_doe=1 and sram_dout=wdata[8i+:8].
  - STROBE (STROBE_CYCLES cycles): oe_bar=0 for read, we_bar=0 for write. Address and data stable. For a read, sram_din is captured into rdata byte i on the clock edge that ends the last STROBE cycle.
  - HOLD (1 cycle): oe_bar and we_bar return to 1. Address, data and doe stay held; ce_bar stays 0. If i<N-1, increment i and go to SETUP; otherwise go to DONE.
  - DONE (1 cycle): ce_bar=1, doe=0, bus_resp=1, bus_ready=0. Next cycle goes to IDLE.
- Latency: bus_resp asserts N*(STROBE_CYCLES+2)+1 cycles after the accept edge. Default timing: byte=4, word=13.
- bus_rdata is updated only for reads and holds its value until the next read completes. Upper unread bytes are zeroed when the read is accepted.
- Writes never change bus_rdata.
- bus_req while busy is ignored; nothing is queued.
- Reset mid-operation: strobes deassert immediately (asynchronous) and the transaction is dropped with no bus_resp.
- we_bar and oe_bar are never low in the same cycle. sram_doe=1 only during write SETUP/STROBE/HOLD.

Optional Feature:
SRAM_CTRL_ALIGN_CHK_EN
- Defined: the following requests generate no SRAM cycle; the FSM goes IDLE->DONE and bus_resp=1 with bus_err=1 one cycle after accept:
  - half with addr[0]=1
  - word with addr[1:0]!=0
  - acc=3
- Undefined: bus_err is tied to 0. Misaligned accesses run byte-sequentially from the given address with wrap; acc=3 is treated as word.

Decomposition:
- Package sram_ctrl_pkg holds:
  - acc_e enum (ACC_BYTE, ACC_HALF, ACC_WORD, ACC_RSVD)
  - state_e enum (S_IDLE, S_SETUP, S_STROBE, S_HOLD, S_DONE)
  - localparam SRAM_DEPTH=1<<19
- No sub-module. The strobe counter (4-bit) and byte index (2-bit) stay inline.

Test Plan:
- Word write 0xDEADBEEF to 0x00100, STROBE_CYCLES=1 -> SRAM bytes 0x100..0x103 = EF,BE,AD,DE; four we_bar pulses each 1 cycle wide; bus_resp 13 cycles after accept; bus_err=0.
- Word read from 0x00100 after the above -> bus_rdata=0xDEADBEEF. Byte read 0x00102 -> 0x000000AD at 4 cycles.
- Half write 0x1234 to 0x7FFFF (macro off) -> byte 0x7FFFF=34, byte 0x00000=12 (wrap).
- Macro on: word read at 0x00101 -> bus_resp with bus_err=1 one cycle after accept; ce_bar never low.
- bus_req held through a busy word write, then a second read -> second request accepted only on the edge bus_ready returns to 1.
- rst pulsed during STROBE of byte 1 of a word write -> we_bar/ce_bar go to 1 immediately, no bus_resp, bus_ready=1 after release.
